spi_sclk_gen: RTL and testbench

SPI_SCLK_GEN -- requirements
Module: spi_sclk_gen

---
 rtl/spi_sclk_gen.sv | 135 +++++++++++++
 tb/tb_spi_sclk_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/spi_sclk_gen.sv
// SPI serial clock generator: runtime half-period divider, burst of nbits SCLK
// cycles with sample/shift strobes, selectable CPOL/CPHA and a trailing guard period.
module spi_sclk_gen #(
   parameter int DIV_W = 10,
   parameter int BIT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start,
   input  logic [DIV_W-1:0] div,
   input  logic [BIT_W-1:0] nbits,
   input  logic             cpol,
   input  logic             cpha,
   output logic             sclk,
   output logic             sample_stb,
   output logic             shift_stb,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_reg, state_next;
   logic [DIV_W-1:0]   cnt_reg, cnt_next;
   logic [BIT_W:0]     edge_reg, edge_next;
   logic [DIV_W-1:0]   div_reg, div_next;
   logic [BIT_W-1:0]   nbits_reg, nbits_next;
   logic               cpol_reg, cpol_next;
   logic               cpha_reg, cpha_next;
   logic               sclk_reg, sclk_next;
   logic               sample_reg, sample_next;
   logic               shift_reg, shift_next;
   logic               done_reg, done_next;

   logic               hp_end;
   logic [BIT_W:0]     last_edge;

   assign hp_end    = (cnt_reg == div_reg);
   assign last_edge = {nbits_reg, 1'b0};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         edge_reg   <= '0;
         div_reg    <= '0;
         nbits_reg  <= '0;
         cpol_reg   <= 1'b0;
         cpha_reg   <= 1'b0;
         sclk_reg   <= 1'b0;
         sample_reg <= 1'b0;
         shift_reg  <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         edge_reg   <= edge_next;
         div_reg    <= div_next;
         nbits_reg  <= nbits_next;
         cpol_reg   <= cpol_next;
         cpha_reg   <= cpha_next;
         sclk_reg   <= sclk_next;
         sample_reg <= sample_next;
         shift_reg  <= shift_next;
         done_reg   <= done_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      edge_next   = edge_reg;
      div_next    = div_reg;
      nbits_next  = nbits_reg;
      cpol_next   = cpol_reg;
      cpha_next   = cpha_reg;
      sclk_next   = sclk_reg;
      sample_next = 1'b0;
      shift_next  = 1'b0;
      done_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            sclk_next = cpol;
            cnt_next  = '0;
            edge_next = '0;
            if (en && start && (nbits != '0)) begin
               state_next = RUN;
               div_next   = div;
               nbits_next = nbits;
               cpol_next  = cpol;
               cpha_next  = cpha;
            end
         end
         RUN: begin
            if (!en) begin
               state_next = IDLE;
               sclk_next  = cpol_reg;
               cnt_next   = '0;
               edge_next  = '0;
            end else if (hp_end) begin
               cnt_next = '0;
               // The half-period after the last toggle is a guard with no edge.
               if (edge_reg == last_edge) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
                  sclk_next  = cpol_reg;
                  edge_next  = '0;
               end else begin
                  edge_next = edge_reg + 1'b1;
                  sclk_next = ~sclk_reg;
                  // edge_reg even means this toggle is odd-numbered, i.e. leading.
                  if (!edge_reg[0]) begin
                     sample_next = ~cpha_reg;
                     shift_next  = cpha_reg;
                  end else begin
                     sample_next = cpha_reg;
                     shift_next  = ~cpha_reg;
                  end
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign sclk       = sclk_reg;
   assign sample_stb = sample_reg;
   assign shift_stb  = shift_reg;
   assign busy       = (state_reg == RUN);
   assign done       = done_reg;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Scoreboard bench for spi_sclk_gen: bursts are predicted as timed edge/done events
// from the timing formulas and compared by an independent negedge monitor.
module tb_spi_sclk_gen;
   localparam int DIV_W = 10;
   localparam int BIT_W = 6;

   logic             clk = 1'b0;
   logic             rst, en, start, cpol, cpha;
   logic [DIV_W-1:0] div;
   logic [BIT_W-1:0] nbits;
   logic             sclk, sample_stb, shift_stb, busy, done;

   spi_sclk_gen #(.DIV_W(DIV_W), .BIT_W(BIT_W)) dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .div(div), .nbits(nbits),
      .cpol(cpol), .cpha(cpha), .sclk(sclk), .sample_stb(sample_stb),
      .shift_stb(shift_stb), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // kind: 0 = sample strobe, 1 = shift strobe, 2 = done
   typedef struct {
      int cyc;
      int kind;
      bit lvl;
      int blen;
   } ev_t;
   ev_t exp_q[$];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: pops an expected event whenever the DUT pulses a strobe or done.
   int   busy_run = 0;
   int   last_run = 0;
   int   mon_kind;
   ev_t  mon_e;
   always @(negedge clk) begin
      if (busy === 1'b1) busy_run++;
      else begin
         if (busy_run > 0) last_run = busy_run;
         busy_run = 0;
      end
      check("stb_exclusive", int'(sample_stb === 1'b1 && shift_stb === 1'b1), 0);
      check("done_while_busy", int'(done === 1'b1 && busy === 1'b1), 0);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         mon_e = exp_q.pop_front();
         check("missed_event_cycle", cyc, mon_e.cyc);
      end
      if (sample_stb === 1'b1 || shift_stb === 1'b1 || done === 1'b1) begin
         mon_kind = (done === 1'b1) ? 2 : ((sample_stb === 1'b1) ? 0 : 1);
         if (exp_q.size() == 0) begin
            check("unexpected_event_kind", mon_kind, -1);
         end else begin
            mon_e = exp_q.pop_front();
            check("event_kind", mon_kind, mon_e.kind);
            check("event_cycle", cyc, mon_e.cyc);
            check("event_sclk", int'(sclk), int'(mon_e.lvl));
            if (mon_e.kind == 2) check("busy_length", last_run, mon_e.blen);
            $display("event kind=%0d cycle=%0d sclk=%0d", mon_kind, cyc, sclk);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // mode 0: full burst, returns in the done cycle; 1: en dropped; 2: rst pulse.
   task automatic burst(input int d, input int n, input bit pol, input bit pha,
                        input int mode, input int ab_off);
      int  T, L, A, c;
      T = cyc;
      L = (2 * n + 1) * (d + 1);
      A = (mode == 0) ? T + L + 10 : T + ((ab_off > 0) ? ab_off : int'($urandom_range(1, L - 1)));
      en = 1'b1; start = 1'b1;
      div = DIV_W'(d); nbits = BIT_W'(n); cpol = pol; cpha = pha;
      $display("burst div=%0d nbits=%0d cpol=%0d cpha=%0d mode=%0d start=%0d", d, n, pol, pha, mode, T);
      for (int k = 1; k <= 2 * n; k++) begin
         c = T + k * (d + 1) + 1;
         if (mode == 0 || c <= A)
            exp_q.push_back('{c, (((k & 1) == 1) ^ pha) ? 0 : 1, pol ^ 1'(k & 1), 0});
      end
      if (mode == 0) exp_q.push_back('{T + L + 1, 2, pol, L});
      step();
      for (int t = T + 1; t <= T + L; t++) begin
         div = DIV_W'($urandom); nbits = BIT_W'($urandom);
         cpol = 1'($urandom); cpha = 1'($urandom);
         start = ($urandom_range(0, 3) == 0);
         if (mode != 0 && t == A) begin
            start = 1'b0;
            if (mode == 1) en = 1'b0;
            else rst = 1'b1;
            step();
            check("abort_busy", int'(busy), 0);
            check("abort_done", int'(done), 0);
            if (mode == 1) begin
               check("abort_sclk", int'(sclk), int'(pol));
               en = 1'b1;
            end else begin
               check("rst_sclk", int'(sclk), 0);
               check("rst_sample", int'(sample_stb), 0);
               check("rst_shift", int'(shift_stb), 0);
               rst = 1'b0;
               cpol = pol;
               step();
               check("rst_recover_busy", int'(busy), 0);
               check("rst_recover_sclk", int'(sclk), int'(pol));
            end
            break;
         end
         step();
      end
      start = 1'b0;
   endtask

   task automatic idle_check();
      bit pol;
      pol = 1'($urandom);
      cpol = pol; start = 1'b0;
      step();
      check("idle_sclk", int'(sclk), int'(pol));
      check("idle_busy", int'(busy), 0);
   endtask

   task automatic zero_start();
      start = 1'b1; nbits = '0; div = DIV_W'($urandom);
      step();
      start = 1'b0;
      check("zero_nbits_busy", int'(busy), 0);
      step();
      check("zero_nbits_busy2", int'(busy), 0);
   endtask

   initial begin
      int mode, d, n;
      rst = 1'b1; en = 1'b0; start = 1'b0; div = '0; nbits = '0; cpol = 1'b0; cpha = 1'b0;
      step(); step();
      check("reset_sclk", int'(sclk), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_sample", int'(sample_stb), 0);
      check("reset_shift", int'(shift_stb), 0);
      // rst must win over a valid start
      en = 1'b1; start = 1'b1; nbits = BIT_W'(2); cpol = 1'b1;
      step();
      check("reset_prio_busy", int'(busy), 0);
      check("reset_prio_sclk", int'(sclk), 0);
      rst = 1'b0; start = 1'b0;
      step();
      check("post_reset_sclk", int'(sclk), 1);

      burst(1, 2, 1'b0, 1'b0, 0, 0);
      idle_check();
      burst(1, 2, 1'b1, 1'b1, 0, 0);
      idle_check();
      burst(0, 1, 1'b0, 1'b0, 0, 0);
      burst(1023, 1, 1'b1, 1'b0, 0, 0);
      idle_check();
      burst(1, 2, 1'b0, 1'b0, 1, 7);
      burst(1, 2, 1'b0, 1'b1, 0, 0);
      idle_check();
      burst(2, 3, 1'b1, 1'b0, 2, 5);
      zero_start();

      for (int i = 0; i < 40; i++) begin
         mode = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
         d = $urandom_range(0, 4);
         n = $urandom_range(1, 6);
         case ($urandom_range(0, 3))
            0: idle_check();
            1: zero_start();
            default: ;
         endcase
         burst(d, n, 1'($urandom), 1'($urandom), mode, 0);
      end

      start = 1'b0;
      repeat (5) step();
      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
